// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
// Handshake: a requester raises *_req and holds every request field stable until it is
// accepted. The core is accepted when cpu_req=1 and cpu_stall=0, and the loader when ld_gnt=1,
// both in the same cycle. For an accepted read, *_rvalid pulses exactly one cycle later.
interface dmem_arbiter_if #(parameter int BUS_WIDTH = 32);
  logic                 cpu_req;
  logic                 cpu_we;
  logic [BUS_WIDTH-1:0] cpu_addr;
  logic [BUS_WIDTH-1:0] cpu_wdata;
  logic [3:0]           cpu_wmask;
  logic                 cpu_stall;
  logic                 cpu_rvalid;
  logic [BUS_WIDTH-1:0] cpu_rdata;
  logic                 core_hold;
  logic                 ld_req;
  logic                 ld_we;
  logic [BUS_WIDTH-1:0] ld_addr;
  logic [BUS_WIDTH-1:0] ld_wdata;
  logic                 ld_done;
  logic                 ld_gnt;
  logic                 ld_rvalid;
  logic [BUS_WIDTH-1:0] ld_rdata;
  logic                 mem_en;
  logic                 mem_we;
  logic [BUS_WIDTH-1:0] mem_addr;
  logic [BUS_WIDTH-1:0] mem_wdata;
  logic [3:0]           mem_wmask;
  logic [BUS_WIDTH-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_done,
    input  mem_rdata,
    output cpu_stall, cpu_rvalid, cpu_rdata, core_hold,
    output ld_gnt, ld_rvalid, ld_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  // Requesters plus memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
    output ld_req, ld_we, ld_addr, ld_wdata, ld_done,
    output mem_rdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata, core_hold,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core MW stage and the UART boot loader.
// It holds the core during boot, then uses round-robin arbitration and steers read returns back.
module dmem_arbiter #(
  parameter int BUS_WIDTH = 32,
  parameter bit BOOT_EN   = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus,
  output logic           dbg_state   // 0 = BOOT, 1 = RUN
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t               state, state_nx;
  logic                 last_ld;     // last grant went to the loader
  logic                 cpu_gnt, ld_gnt_c;
  logic                 pend_cpu, pend_ld;
  logic [BUS_WIDTH-1:0] cpu_rdata_q, ld_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT_EN ? BOOT : RUN;
    else     state <= state_nx;
  end

  // Next state and arbitration. The core is never granted during boot.
  always_comb begin
    state_nx = state;
    cpu_gnt  = 1'b0;
    ld_gnt_c = 1'b0;
    if (state == BOOT) begin
      ld_gnt_c = bus.ld_req;
      if (bus.ld_done) state_nx = RUN;
    end else if (bus.cpu_req && bus.ld_req) begin
      cpu_gnt  = last_ld;
      ld_gnt_c = ~last_ld;
    end else begin
      cpu_gnt  = bus.cpu_req;
      ld_gnt_c = bus.ld_req;
    end
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = 4'h0;
    if (cpu_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_wmask = bus.cpu_wmask;
    end else if (ld_gnt_c) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.ld_we;
      bus.mem_addr  = bus.ld_addr;
      bus.mem_wdata = bus.ld_wdata;
      bus.mem_wmask = 4'hF;
    end
  end

  // One owner tag per cycle lets back-to-back reads return at full rate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ld     <= 1'b1;
      pend_cpu    <= 1'b0;
      pend_ld     <= 1'b0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      if (cpu_gnt)       last_ld <= 1'b0;
      else if (ld_gnt_c) last_ld <= 1'b1;
      pend_cpu <= cpu_gnt & ~bus.cpu_we;
      pend_ld  <= ld_gnt_c & ~bus.ld_we;
      if (pend_cpu) cpu_rdata_q <= bus.mem_rdata;
      if (pend_ld)  ld_rdata_q  <= bus.mem_rdata;
    end
  end

  // Return data passes straight through in the return cycle and is held afterwards.
  assign bus.cpu_rvalid = pend_cpu;
  assign bus.ld_rvalid  = pend_ld;
  assign bus.cpu_rdata  = pend_cpu ? bus.mem_rdata : cpu_rdata_q;
  assign bus.ld_rdata   = pend_ld  ? bus.mem_rdata : ld_rdata_q;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
  assign bus.ld_gnt     = ld_gnt_c;
  assign bus.core_hold  = (state == BOOT);
  assign dbg_state      = (state == RUN);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic, all compared
// against a transaction-level model with a shadow memory and an expected read-return queue.
module tb_dmem_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.BUS_WIDTH(W)) bus ();
  dmem_arbiter_if #(.BUS_WIDTH(W)) bus_r ();
  logic dbg_state, dbg_state_r;

  dmem_arbiter #(.BUS_WIDTH(W), .BOOT_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .dbg_state(dbg_state));

  // Second instance without a boot phase; it shares the core stimulus and sees no loader.
  dmem_arbiter #(.BUS_WIDTH(W), .BOOT_EN(1'b0)) u_run (
    .clk(clk), .rst(rst), .bus(bus_r.slave), .dbg_state(dbg_state_r));

  assign bus_r.cpu_req   = bus.cpu_req;
  assign bus_r.cpu_we    = bus.cpu_we;
  assign bus_r.cpu_addr  = bus.cpu_addr;
  assign bus_r.cpu_wdata = bus.cpu_wdata;
  assign bus_r.cpu_wmask = bus.cpu_wmask;
  assign bus_r.ld_req    = 1'b0;
  assign bus_r.ld_we     = 1'b0;
  assign bus_r.ld_addr   = '0;
  assign bus_r.ld_wdata  = '0;
  assign bus_r.ld_done   = 1'b0;
  assign bus_r.mem_rdata = '0;

  // ---------------- memory behind the arbiter ----------------
  logic [W-1:0] ram [64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_en && bus.mem_we)
        for (int b = 0; b < 4; b++)
          if (bus.mem_wmask[b]) ram[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr[7:2]] : $urandom;
    end
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit           m_boot;
  bit           m_last_ld;
  logic [W-1:0] shadow [64];
  logic [W-1:0] held_cpu, held_ld;
  logic [W-1:0] exp_q[$];
  bit           own_q[$];   // 1 = loader
  int           due_q[$];
  int           cyc = 0;
  bit           e_cpu_rv, e_ld_rv, g_cpu, g_ld, e_we;
  logic [W-1:0] e_addr, e_wdata;
  logic [3:0]   e_mask;

  always @(negedge clk) begin
    if (rst) begin
      m_boot = 1'b1;
      m_last_ld = 1'b1;
      held_cpu = '0;
      held_ld = '0;
      exp_q.delete(); own_q.delete(); due_q.delete();
      for (int i = 0; i < 64; i++) shadow[i] = '0;
      chk1("rst_core_hold", bus.core_hold, 1'b1);
      chk1("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
      chk1("rst_ld_rvalid", bus.ld_rvalid, 1'b0);
      chk("rst_cpu_rdata", bus.cpu_rdata, '0);
    end else begin
      // read returns expected this cycle
      e_cpu_rv = 1'b0;
      e_ld_rv = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        if (own_q[0]) begin e_ld_rv = 1'b1; held_ld = exp_q[0]; end
        else          begin e_cpu_rv = 1'b1; held_cpu = exp_q[0]; end
        void'(due_q.pop_front()); void'(own_q.pop_front()); void'(exp_q.pop_front());
      end
      chk1("cpu_rvalid", bus.cpu_rvalid, e_cpu_rv);
      chk1("ld_rvalid", bus.ld_rvalid, e_ld_rv);
      chk("cpu_rdata", bus.cpu_rdata, held_cpu);
      chk("ld_rdata", bus.ld_rdata, held_ld);

      // who wins the port this cycle
      g_cpu = 1'b0;
      g_ld = 1'b0;
      if (m_boot)                           g_ld = bus.ld_req;
      else if (bus.cpu_req && bus.ld_req) begin
        if (m_last_ld) g_cpu = 1'b1; else g_ld = 1'b1;
      end else begin
        g_cpu = bus.cpu_req;
        g_ld = bus.ld_req;
      end
      e_we = 1'b0; e_addr = '0; e_wdata = '0; e_mask = 4'h0;
      if (g_cpu) begin
        e_we = bus.cpu_we; e_addr = bus.cpu_addr; e_wdata = bus.cpu_wdata; e_mask = bus.cpu_wmask;
      end else if (g_ld) begin
        e_we = bus.ld_we; e_addr = bus.ld_addr; e_wdata = bus.ld_wdata; e_mask = 4'hF;
      end
      chk1("cpu_stall", bus.cpu_stall, bus.cpu_req & ~g_cpu);
      chk1("ld_gnt", bus.ld_gnt, g_ld);
      chk1("core_hold", bus.core_hold, m_boot);
      chk1("mem_en", bus.mem_en, g_cpu | g_ld);
      chk1("mem_we", bus.mem_we, e_we);
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_wdata", bus.mem_wdata, e_wdata);
      chk("mem_wmask", 32'(bus.mem_wmask), 32'(e_mask));

      // commit the transaction into the model
      if (g_cpu || g_ld) begin
        if (e_we) begin
          for (int b = 0; b < 4; b++)
            if (e_mask[b]) shadow[e_addr[7:2]][8*b +: 8] = e_wdata[8*b +: 8];
        end else begin
          due_q.push_back(cyc + 1);
          own_q.push_back(g_ld);
          exp_q.push_back(shadow[e_addr[7:2]]);
        end
        m_last_ld = g_ld;
      end
      if (m_boot && bus.ld_done) m_boot = 1'b0;
    end
    cyc++;
  end

  // counts memory writes to 0x20 during the stalled-store scenario
  bit win = 1'b0;
  int wr20 = 0;
  always @(negedge clk)
    if (win && bus.mem_en && bus.mem_we && bus.mem_addr == 32'h20) wr20++;

  // ---------------- drivers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input bit req, input bit we, input logic [W-1:0] a,
                         input logic [W-1:0] d, input logic [3:0] m);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_wmask = m;
  endtask

  task automatic set_ld(input bit req, input bit we, input logic [W-1:0] a, input logic [W-1:0] d);
    bus.ld_req = req; bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = d;
  endtask

  bit hold_c, hold_l;

  initial begin
    set_cpu(1'b0, 1'b0, '0, '0, 4'h0);
    set_ld(1'b0, 1'b0, '0, '0);
    bus.ld_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_dbg_boot", dbg_state, 1'b0);
    chk1("rst_run_state", dbg_state_r, 1'b1);
    chk1("rst_run_core_hold", bus_r.core_hold, 1'b0);
    rst = 1'b0;

    // boot load with the core requesting throughout
    set_cpu(1'b1, 1'b0, 32'h8, '0, 4'hF);
    set_ld(1'b1, 1'b1, 32'h0, 32'h00000013);
    @(negedge clk);
    chk1("boot1_ld_gnt", bus.ld_gnt, 1'b1);
    chk("boot1_wmask", 32'(bus.mem_wmask), 32'hF);
    chk1("boot1_core_hold", bus.core_hold, 1'b1);
    chk1("boot1_cpu_stall", bus.cpu_stall, 1'b1);
    next_cycle();
    set_ld(1'b1, 1'b1, 32'h4, 32'h00100093);
    @(negedge clk);
    chk1("boot2_ld_gnt", bus.ld_gnt, 1'b1);
    chk("boot2_wdata", bus.mem_wdata, 32'h00100093);
    chk1("boot2_cpu_stall", bus.cpu_stall, 1'b1);
    next_cycle();
    set_ld(1'b0, 1'b0, '0, '0);
    bus.ld_done = 1'b1;
    @(negedge clk);
    chk1("done_core_hold", bus.core_hold, 1'b1);
    next_cycle();
    bus.ld_done = 1'b0;
    @(negedge clk);
    chk1("run_core_hold", bus.core_hold, 1'b0);
    chk1("run_cpu_stall", bus.cpu_stall, 1'b0);

    // solo core read of 0x4
    next_cycle();
    set_cpu(1'b1, 1'b0, 32'h4, '0, 4'hF);
    @(negedge clk);
    chk1("solo_mem_en", bus.mem_en, 1'b1);
    chk1("solo_cpu_stall", bus.cpu_stall, 1'b0);
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0, 4'h0);
    @(negedge clk);
    chk1("solo_cpu_rvalid", bus.cpu_rvalid, 1'b1);
    chk("solo_cpu_rdata", bus.cpu_rdata, 32'h00100093);
    chk1("solo_ld_rvalid", bus.ld_rvalid, 1'b0);

    // loader write so the last grant is LD, then contention
    next_cycle();
    set_ld(1'b1, 1'b1, 32'h30, 32'h12345678);
    @(negedge clk);
    next_cycle();
    set_cpu(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    set_ld(1'b1, 1'b0, 32'h10, '0);
    @(negedge clk);
    chk1("cont1_cpu_stall", bus.cpu_stall, 1'b0);
    chk1("cont1_ld_gnt", bus.ld_gnt, 1'b0);
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0, 4'h0);
    @(negedge clk);
    chk1("cont2_ld_gnt", bus.ld_gnt, 1'b1);
    next_cycle();
    set_ld(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk1("cont3_ld_rvalid", bus.ld_rvalid, 1'b1);
    chk("cont3_ld_rdata", bus.ld_rdata, 32'hDEADBEEF);

    // sustained read contention: CPU,LD,CPU,LD,CPU,LD
    next_cycle();
    set_cpu(1'b1, 1'b0, 32'h4, '0, 4'hF);
    set_ld(1'b1, 1'b0, 32'h10, '0);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin
        next_cycle();
        set_cpu(1'b0, 1'b0, '0, '0, 4'h0);
        set_ld(1'b0, 1'b0, '0, '0);
      end
      @(negedge clk);
      if (i < 6) chk1($sformatf("sus%0d_ld_gnt", i), bus.ld_gnt, (i % 2) == 1);
      if (i > 0) begin
        chk1($sformatf("sus%0d_cpu_rv", i), bus.cpu_rvalid, ((i - 1) % 2) == 0);
        chk1($sformatf("sus%0d_ld_rv", i), bus.ld_rvalid, ((i - 1) % 2) == 1);
      end
    end

    // core read makes the core last, then the loader wins over a store
    next_cycle();
    set_cpu(1'b1, 1'b0, 32'h0, '0, 4'hF);
    @(negedge clk);
    next_cycle();
    set_cpu(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'b0011);
    set_ld(1'b1, 1'b1, 32'h24, 32'hCAFEF00D);
    win = 1'b1;
    @(negedge clk);
    chk1("st1_ld_gnt", bus.ld_gnt, 1'b1);
    chk1("st1_cpu_stall", bus.cpu_stall, 1'b1);
    chk("st1_mem_addr", bus.mem_addr, 32'h24);
    next_cycle();
    set_ld(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk1("st2_cpu_stall", bus.cpu_stall, 1'b0);
    chk("st2_mem_wmask", 32'(bus.mem_wmask), 32'h3);
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0, 4'h0);
    win = 1'b0;
    chk("st_write_count", wr20, 1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      hold_c = bus.cpu_req && bus.cpu_stall;
      hold_l = bus.ld_req && !bus.ld_gnt;
      next_cycle();
      if (!hold_c)
        set_cpu($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                32'($urandom_range(0, 15)) << 2, $urandom, 4'($urandom_range(0, 15)));
      if (!hold_l)
        set_ld($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
               32'($urandom_range(0, 15)) << 2, $urandom);
      bus.ld_done = ($urandom_range(0, 15) == 0);
    end

    // reset in the middle of a read return
    next_cycle();
    set_cpu(1'b1, 1'b0, 32'h4, '0, 4'hF);
    set_ld(1'b0, 1'b0, '0, '0);
    bus.ld_done = 1'b0;
    @(negedge clk);
    chk1("mr_cpu_stall", bus.cpu_stall, 1'b0);
    next_cycle();
    set_cpu(1'b0, 1'b0, '0, '0, 4'h0);
    chk1("mr_pre_cpu_rvalid", bus.cpu_rvalid, 1'b1);
    chk1("mr_pre_run_rvalid", bus_r.cpu_rvalid, 1'b1);
    rst = 1'b1;
    #1;
    chk1("mr_cpu_rvalid", bus.cpu_rvalid, 1'b0);
    chk1("mr_core_hold", bus.core_hold, 1'b1);
    chk1("mr_state_boot", dbg_state, 1'b0);
    chk1("mr_run_rvalid", bus_r.cpu_rvalid, 1'b0);
    chk1("mr_run_core_hold", bus_r.core_hold, 1'b0);
    chk1("mr_run_state", dbg_state_r, 1'b1);
    next_cycle();
    rst = 1'b0;
    repeat (4) next_cycle();
    chk1("end_core_hold", bus.core_hold, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single-port synchronous data memory between two requesters: the core's MW-stage load/store port, and the UART boot loader that writes program/data images received over uart_s_in.
- Sequences the boot phase: holds the core until the loader signals completion, then shares the port round-robin.
- Generates the core stall and routes 1-cycle-latency read data back to the requester that issued the read.

Parameters:
- BUS_WIDTH, 32, data and address width.
- BOOT_EN, 1, 1 = leave reset in BOOT state; 0 = leave reset directly in RUN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  core memory access request (MW stage).
- cpu_we  in  1  core write enable.
- cpu_addr  in  BUS_WIDTH  core byte address.
- cpu_wdata  in  BUS_WIDTH  core write data.
- cpu_wmask  in  4  core byte-lane mask.
- cpu_stall  out  1  core must hold its request and stall the pipeline.
- cpu_rvalid  out  1  core read data valid.
- cpu_rdata  out  BUS_WIDTH  core read data.
- core_hold  out  1  keeps the core frozen during boot.
- ld_req  in  1  loader request; held high until granted.
- ld_we  in  1  loader write enable.
- ld_addr  in  BUS_WIDTH  loader byte address.
- ld_wdata  in  BUS_WIDTH  loader write data.
- ld_done  in  1  single-cycle pulse: image load complete.
- ld_gnt  out  1  loader request accepted this cycle.
- ld_rvalid  out  1  loader read data valid.
- ld_rdata  out  BUS_WIDTH  loader read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  BUS_WIDTH  memory address.
- mem_wdata  out  BUS_WIDTH  memory write data.
- mem_wmask  out  4  memory byte mask.
- mem_rdata  in  BUS_WIDTH  memory read data; valid the cycle after mem_en=1 with mem_we=0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - State = BOOT if BOOT_EN=1, else RUN.
  - last_gnt = LD.
  - All rvalid outputs, the pending-read owner tag and grants = 0.
  - rdata outputs = 0.
- FSM state BOOT:
  - core_hold=1.
  - Only the loader can be granted; cpu_stall=cpu_req.
  - ld_done=1 moves the state to RUN at the next edge. A loader grant in the same cycle as ld_done still completes.
- FSM state RUN:
  - core_hold=0.
  - ld_done is ignored.
  - RUN is left only by reset.
- Arbitration (combinational, same cycle):
  - Only one requester active: it is granted.
  - Both active in RUN: grant goes to the requester that was not last_gnt (round-robin).
  - last_gnt updates on every grant.
- Granted requester's signals drive the mem_* outputs with mem_en=1.
  - Loader writes always use mem_wmask=4'hF.
  - No grant: mem_en=0, mem_we=0, other mem_* = 0.
- cpu_stall = cpu_req & ~cpu_grant.
  - The core holds address, data and mask stable while stalled.
  - A stalled write must not reach memory.
- ld_gnt = loader granted.
- Read return:
  - A granted read (we=0) registers a pending-owner tag.
  - Next cycle, that owner's rvalid=1 and its rdata = mem_rdata, registered so it holds until the next return to that owner.
  - The other owner's rvalid stays 0.
- Back-to-back reads are allowed. Each cycle carries an independent tag, so returns are pipelined at one per cycle.
- Writes produce no rvalid.
- Reset mid-operation: pending tags are discarded, no rvalid is emitted after reset, the FSM returns to its reset state, and any in-flight grant is lost.
- Address alignment and mask legality are the requester's responsibility; the arbiter passes them unchanged.

Test Plan:
- Boot load: BOOT_EN=1; loader writes 0x00000013 to addr 0x0 and 0x00100093 to addr 0x4 while cpu_req=1.
  - Required: both ld_gnt, mem_wmask=4'hF, core_hold=1, cpu_stall=1 throughout.
  - Pulse ld_done: core_hold drops the following cycle.
- Solo core read in RUN: cpu_req=1, we=0, addr 0x4.
  - Required: mem_en=1 same cycle, cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=0x00100093, ld_rvalid=0.
- Contention: RUN, last_gnt=LD; cpu write 0xDEADBEEF to 0x10 (mask 4'hF) and loader read of 0x10 asserted in the same cycle.
  - Required: cycle 1 cpu granted, ld_gnt=0; cycle 2 loader granted, cpu_req dropped; cycle 3 ld_rvalid=1, ld_rdata=0xDEADBEEF.
- Sustained contention, both requesting reads for 6 cycles: grants alternate CPU,LD,CPU,LD,CPU,LD; the rvalid owner sequence matches, one cycle delayed.
- Stalled store: loader granted while cpu_we=1 to 0x20 with mask 4'b0011.
  - Required: no memory write while cpu_stall=1; exactly one write with mask 4'b0011 once granted.
- Reset mid-read: assert rst the cycle after a granted core read.
  - Required: cpu_rvalid=0, state BOOT, core_hold=1 immediately (asynchronous).
  - Repeat with BOOT_EN=0: required state RUN and core_hold=0 after reset.
